// File: rtl/tri_debug_trace_pkg.sv
// Shared constants for the debug trace capture block: FSM state encodings and
// coretrace control bit positions.
package tri_debug_trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    localparam int CTRL_VALID   = 0;
    localparam int CTRL_EXTTRIG = 1;
    localparam int TS_W         = 16;

endpackage

// File: rtl/tri_debug_trace_if.sv
// Bundle of trace input, configuration, readout stream and status signals.
// Optional trig_timestamp appears when TRI_DEBUG_TRACE_TIMESTAMP_EN is defined.
interface tri_debug_trace_if #(
    parameter int DBG_WIDTH = 32,
    parameter int ADDR_W    = 4
);
    logic [DBG_WIDTH-1:0] trace_data_in;
    logic [3:0]           coretrace_ctrls_in;
    logic                 cfg_arm;
    logic                 cfg_abort;
    logic [DBG_WIDTH-1:0] cfg_pattern;
    logic [DBG_WIDTH-1:0] cfg_mask;
    logic                 cfg_ext_trig_en;
    logic [ADDR_W-1:0]    cfg_post_cnt;
    // Readout stream: a beat transfers on a cycle with rd_valid & rd_ready;
    // while rd_valid is high and rd_ready low, rd_data/rd_last stay constant
    // and rd_valid is not withdrawn except by cfg_abort.
    logic                 rd_start;
    logic                 rd_ready;
    logic                 rd_valid;
    logic [DBG_WIDTH-1:0] rd_data;
    logic                 rd_last;
    logic [2:0]           state_out;
    logic                 triggered;
    logic [ADDR_W-1:0]    trig_addr;
    logic                 wrapped;
`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
    logic [0:15]          trig_timestamp;
`endif

    modport master (
`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
        input  trig_timestamp,
`endif
        output trace_data_in, coretrace_ctrls_in, cfg_arm, cfg_abort,
               cfg_pattern, cfg_mask, cfg_ext_trig_en, cfg_post_cnt,
               rd_start, rd_ready,
        input  rd_valid, rd_data, rd_last, state_out, triggered,
               trig_addr, wrapped
    );

    modport slave (
`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
        output trig_timestamp,
`endif
        input  trace_data_in, coretrace_ctrls_in, cfg_arm, cfg_abort,
               cfg_pattern, cfg_mask, cfg_ext_trig_en, cfg_post_cnt,
               rd_start, rd_ready,
        output rd_valid, rd_data, rd_last, state_out, triggered,
               trig_addr, wrapped
    );

endinterface

// File: rtl/tri_debug_trace_buf.sv
// Trace storage: DEPTH x WIDTH array with one write port and one registered
// read port. The array itself is not reset; only the read register is.
module tri_debug_trace_buf #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tri_debug_trace_capture.sv
// Debug trace capture: masked-pattern / external trigger, circular pre-trigger
// history, post-trigger fill, oldest-first readout. Optional trigger timestamp
// is built when TRI_DEBUG_TRACE_TIMESTAMP_EN is defined.
module tri_debug_trace_capture
    import tri_debug_trace_pkg::*;
#(
    parameter int DBG_WIDTH = 32,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tri_debug_trace_if.slave   bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d, trig_addr_q, trig_addr_d;
    logic [ADDR_W:0]     fetch_cnt_q, fetch_cnt_d;
    logic                wrapped_q, wrapped_d, triggered_q, triggered_d;
    logic                rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic                qual, match, trig, wr_en, rd_en, hs;
    logic [1:0]          unused_ctrls;

    assign unused_ctrls = bus.coretrace_ctrls_in[3:2];
    assign qual  = bus.coretrace_ctrls_in[CTRL_VALID];
    assign match = ((bus.trace_data_in ^ bus.cfg_pattern) & bus.cfg_mask) == '0;
    assign trig  = qual & (match | (bus.cfg_ext_trig_en & bus.coretrace_ctrls_in[CTRL_EXTTRIG]));
    assign hs    = rd_valid_q & bus.rd_ready;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        fetch_cnt_d = fetch_cnt_q;
        wrapped_d   = wrapped_q;
        triggered_d = triggered_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        if (bus.cfg_abort) begin
            // Abort overrides any arm, trigger or read activity this cycle.
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cfg_arm) begin
                        state_d     = ST_ARMED;
                        wr_ptr_d    = '0;
                        wrapped_d   = 1'b0;
                        triggered_d = 1'b0;
                        trig_addr_d = '0;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (qual) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (&wr_ptr_q) wrapped_d = 1'b1;
                        if (state_q == ST_ARMED) begin
                            if (trig) begin
                                trig_addr_d = wr_ptr_q;
                                triggered_d = 1'b1;
                                post_cnt_d  = bus.cfg_post_cnt;
                                state_d     = (bus.cfg_post_cnt == '0) ? ST_DONE : ST_POST;
                            end
                        end else begin
                            post_cnt_d = post_cnt_q - 1'b1;
                            if (post_cnt_q == ADDR_W'(1)) state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rd_start) begin
                        state_d     = ST_READ;
                        rd_ptr_d    = wrapped_q ? wr_ptr_q : '0;
                        fetch_cnt_d = wrapped_q ? FULL_CNT : {1'b0, wr_ptr_q};
                    end
                end
                ST_READ: begin
                    // Fetch the next entry whenever the output register is empty or draining.
                    if ((fetch_cnt_q != '0) && (!rd_valid_q || bus.rd_ready)) begin
                        rd_en       = 1'b1;
                        rd_valid_d  = 1'b1;
                        rd_last_d   = (fetch_cnt_q == (ADDR_W+1)'(1));
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                        fetch_cnt_d = fetch_cnt_q - 1'b1;
                    end else if (hs) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        if (rd_last_q) state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            fetch_cnt_q <= '0;
            wrapped_q   <= 1'b0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            fetch_cnt_q <= fetch_cnt_d;
            wrapped_q   <= wrapped_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    tri_debug_trace_buf #(
        .WIDTH  (DBG_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.trace_data_in),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (bus.rd_data)
    );

`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q, trig_ts_q, trig_ts_d;
    logic            ts_arm, ts_trig;

    assign ts_arm  = (state_q == ST_IDLE)  & bus.cfg_arm & ~bus.cfg_abort;
    assign ts_trig = (state_q == ST_ARMED) & trig & ~bus.cfg_abort;

    always_comb begin
        trig_ts_d = trig_ts_q;
        if (ts_trig)     trig_ts_d = ts_cnt_q;
        else if (ts_arm) trig_ts_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt_q  <= '0;
            trig_ts_q <= '0;
        end else begin
            ts_cnt_q  <= ts_cnt_q + 1'b1;
            trig_ts_q <= trig_ts_d;
        end
    end

    assign bus.trig_timestamp = trig_ts_q;
`endif

    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.state_out = state_q;
    assign bus.triggered = triggered_q;
    assign bus.trig_addr = trig_addr_q;
    assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_tri_debug_trace_capture.sv
// Self-checking bench for tri_debug_trace_capture: directed scenarios plus
// randomized captures against a history-queue reference model.
module tb_tri_debug_trace_capture;
    import tri_debug_trace_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tri_debug_trace_if #(.DBG_WIDTH(W), .ADDR_W(AW)) bus ();

    tri_debug_trace_capture #(.DBG_WIDTH(W), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: every sample written since arm, in order.
    logic [W-1:0] wr_hist[$];
    logic [W-1:0] exp_q[$];
    int           trig_idx;
    int           remaining;
    logic [2:0]   exp_state;

`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
    logic [15:0] cyc_cnt;
    logic [15:0] exp_ts;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_cnt <= '0;
        else        cyc_cnt <= cyc_cnt + 16'd1;
    end
`endif

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_defaults();
        bus.trace_data_in      = '0;
        bus.coretrace_ctrls_in = '0;
        bus.cfg_arm            = 1'b0;
        bus.cfg_abort          = 1'b0;
        bus.cfg_pattern        = '0;
        bus.cfg_mask           = '0;
        bus.cfg_ext_trig_en    = 1'b0;
        bus.cfg_post_cnt       = '0;
        bus.rd_start           = 1'b0;
        bus.rd_ready           = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_state"},     bus.state_out, ST_IDLE);
        check_val({tag, "_rd_valid"},  bus.rd_valid, 0);
        check_val({tag, "_rd_data"},   bus.rd_data, 0);
        check_val({tag, "_rd_last"},   bus.rd_last, 0);
        check_val({tag, "_triggered"}, bus.triggered, 0);
        check_val({tag, "_trig_addr"}, bus.trig_addr, 0);
        check_val({tag, "_wrapped"},   bus.wrapped, 0);
    endtask

    task automatic do_arm();
        bus.cfg_arm = 1'b1;
        bus.coretrace_ctrls_in = '0;
        step();
        bus.cfg_arm = 1'b0;
        wr_hist.delete();
        trig_idx  = -1;
        remaining = 0;
        exp_state = ST_ARMED;
        check_val("arm_state",     bus.state_out, ST_ARMED);
        check_val("arm_triggered", bus.triggered, 0);
        check_val("arm_wrapped",   bus.wrapped, 0);
        check_val("arm_trig_addr", bus.trig_addr, 0);
    endtask

    // mode 0: valid always, random data; 1: incrementing data with 0xDEAD1234
    // at sample 20; 2: valid every other cycle; 3: random valid/ext bit;
    // 4: valid + ext bit, data never equal to the pattern.
    task automatic capture(input int mode, input int max_cycles);
        logic [W-1:0] d;
        logic [3:0]   c;
        bit           is_trig;
        int           sample_no = 0;
        for (int k = 0; k < max_cycles && exp_state != ST_DONE; k++) begin
            case (mode)
                0: begin d = $urandom; c = {2'($urandom_range(0, 3)), 1'b0, 1'b1}; end
                1: begin d = (sample_no == 20) ? 32'hDEAD1234 : W'(sample_no); c = 4'b0001; end
                2: begin d = $urandom; c = {3'b000, 1'(k % 2 == 0)}; end
                3: begin
                    d = $urandom;
                    c = {2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0),
                         1'($urandom_range(0, 3) != 0)};
                end
                default: begin
                    d = $urandom;
                    if (d == bus.cfg_pattern) d = ~d;
                    c = {2'($urandom_range(0, 3)), 2'b11};
                end
            endcase
            if (c[0]) sample_no++;
            bus.trace_data_in      = d;
            bus.coretrace_ctrls_in = c;
            is_trig = c[0] && ((((d ^ bus.cfg_pattern) & bus.cfg_mask) == '0) ||
                               (bus.cfg_ext_trig_en && c[1]));
            if (exp_state == ST_ARMED && c[0]) begin
                wr_hist.push_back(d);
                if (is_trig) begin
                    trig_idx  = wr_hist.size() - 1;
                    remaining = int'(bus.cfg_post_cnt);
                    exp_state = (remaining == 0) ? ST_DONE : ST_POST;
`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
                    exp_ts = cyc_cnt;
`endif
                end
            end else if (exp_state == ST_POST && c[0]) begin
                wr_hist.push_back(d);
                remaining--;
                if (remaining == 0) exp_state = ST_DONE;
            end
            step();
            check_val("cap_state",     bus.state_out, exp_state);
            check_val("cap_triggered", bus.triggered, trig_idx >= 0);
        end
        bus.coretrace_ctrls_in = '0;
    endtask

    task automatic check_done();
        check_val("done_state",     bus.state_out, ST_DONE);
        check_val("done_triggered", bus.triggered, 1);
        check_val("done_trig_addr", bus.trig_addr, trig_idx % DEPTH);
        check_val("done_wrapped",   bus.wrapped, wr_hist.size() >= DEPTH);
`ifdef TRI_DEBUG_TRACE_TIMESTAMP_EN
        check_val("done_trig_ts",   bus.trig_timestamp, exp_ts);
`endif
    endtask

    // rmode 0: ready always; 1: random ready; 2: 3-cycle stall after 3 beats.
    task automatic read_out(input int rmode);
        int           n, first_k, hs_cnt, stall_left, got;
        bit           done, stall_pend, rdy;
        logic [W-1:0] held_data, e;
        logic         held_last;
        exp_q.delete();
        n = (wr_hist.size() > DEPTH) ? DEPTH : wr_hist.size();
        for (int i = wr_hist.size() - n; i < wr_hist.size(); i++) exp_q.push_back(wr_hist[i]);
        bus.rd_start = 1'b1;
        bus.rd_ready = 1'b0;
        step();
        bus.rd_start = 1'b0;
        check_val("read_state", bus.state_out, ST_READ);
        first_k = -1; hs_cnt = 0; stall_left = 3; got = 0;
        done = 1'b0; stall_pend = 1'b0; held_data = '0; held_last = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (bus.rd_valid && first_k < 0) first_k = k;
            if (stall_pend) begin
                check_val("hold_valid", bus.rd_valid, 1);
                check_val("hold_data",  bus.rd_data, held_data);
                check_val("hold_last",  bus.rd_last, held_last);
            end else if (rmode == 0 && first_k >= 0) begin
                check_val("b2b_valid", bus.rd_valid, 1);
            end
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(hs_cnt == 3 && stall_left > 0 && bus.rd_valid);
                    if (!rdy) stall_left--;
                end
            endcase
            bus.rd_ready = rdy;
            if (bus.rd_valid && rdy) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("rd_data", bus.rd_data, e);
                    check_val("rd_last", bus.rd_last, exp_q.size() == 0);
                end
                got++;
                hs_cnt++;
                if (bus.rd_last) done = 1'b1;
                stall_pend = 1'b0;
            end else if (bus.rd_valid) begin
                held_data  = bus.rd_data;
                held_last  = bus.rd_last;
                stall_pend = 1'b1;
            end
            step();
        end
        bus.rd_ready = 1'b0;
        check_val("read_done",        done, 1);
        check_val("entry_count",      got, n);
        check_val("rd_latency",       (first_k >= 0) && (first_k <= 1), 1);
        check_val("idle_after_read",  bus.state_out, ST_IDLE);
        check_val("valid_after_read", bus.rd_valid, 0);
        exp_state = ST_IDLE;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_defaults();
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        check_val("post_reset_state", bus.state_out, ST_IDLE);

        // Any qualified sample triggers; 4 writes total.
        bus.cfg_mask = '0;
        bus.cfg_post_cnt = 4'd3;
        do_arm();
        capture(0, 20);
        check_done();
        check_val("a_size", wr_hist.size(), 4);
        read_out(0);
        check_val("a_sticky_trig", bus.triggered, 1);

        // rd_start ignored outside DONE; abort beats a simultaneous arm.
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
        check_val("rdstart_ignored", bus.state_out, ST_IDLE);
        bus.cfg_arm = 1'b1;
        bus.cfg_abort = 1'b1;
        step();
        bus.cfg_arm = 1'b0;
        bus.cfg_abort = 1'b0;
        check_val("abort_arm_state", bus.state_out, ST_IDLE);
        check_val("abort_arm_trig",  bus.triggered, 0);
        step();
        check_val("abort_arm_stay",  bus.state_out, ST_IDLE);

        // Pattern trigger at sample 20 after wrap, readout with a mid-stream stall.
        bus.cfg_pattern = 32'hDEAD0000;
        bus.cfg_mask    = 32'hFFFF0000;
        bus.cfg_post_cnt = 4'd5;
        do_arm();
        capture(1, 100);
        check_done();
        check_val("b_trig_addr", bus.trig_addr, 4);
        check_val("b_wrapped",   bus.wrapped, 1);
        read_out(2);

        // Valid toggling during POST stretches the post-trigger window.
        bus.cfg_mask = '0;
        bus.cfg_post_cnt = 4'd6;
        do_arm();
        capture(2, 100);
        check_done();
        read_out(1);

        // Abort while in POST.
        bus.cfg_post_cnt = 4'd10;
        do_arm();
        capture(0, 4);
        check_val("post_before_abort", bus.state_out, ST_POST);
        bus.cfg_abort = 1'b1;
        step();
        bus.cfg_abort = 1'b0;
        check_val("abort_post_state", bus.state_out, ST_IDLE);
        check_val("abort_post_trig",  bus.triggered, 0);
        check_val("abort_post_valid", bus.rd_valid, 0);
        exp_state = ST_IDLE;

        // External trigger: disabled first (must not fire), then enabled.
        bus.cfg_pattern = 32'hA5A5A5A5;
        bus.cfg_mask    = 32'hFFFFFFFF;
        bus.cfg_ext_trig_en = 1'b0;
        bus.cfg_post_cnt = 4'd2;
        do_arm();
        capture(4, 10);
        check_val("ext_off_state", bus.state_out, ST_ARMED);
        check_val("ext_off_trig",  bus.triggered, 0);
        bus.cfg_abort = 1'b1;
        step();
        bus.cfg_abort = 1'b0;
        bus.cfg_ext_trig_en = 1'b1;
        do_arm();
        capture(4, 10);
        check_done();
        check_val("ext_on_trig_addr", bus.trig_addr, 0);
        read_out(0);
        bus.cfg_ext_trig_en = 1'b0;

        // Randomized captures including post counts 0 and DEPTH-1.
        for (int it = 0; it < 6; it++) begin
            bus.cfg_pattern     = $urandom;
            bus.cfg_mask        = W'($urandom_range(0, 7));
            bus.cfg_ext_trig_en = 1'($urandom_range(0, 1));
            bus.cfg_post_cnt    = (it == 0) ? 4'd0 : (it == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            do_arm();
            capture(3, 400);
            check_done();
            read_out(1);
        end

        // Reset in the middle of a capture.
        bus.cfg_mask = '0;
        bus.cfg_post_cnt = 4'd10;
        do_arm();
        capture(0, 3);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        step();
        rst_n = 1'b1;
        step();
        check_val("after_midreset_state", bus.state_out, ST_IDLE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
